// File: rtl/nic_vc_scheduler_if.sv
// rtl/nic_vc_scheduler_if.sv - injection buffer and router link signals of the VC scheduler
interface nic_vc_scheduler_if #(
  parameter int N_TOT_OF_VC = 4,
  parameter int FLIT_WIDTH  = 16
);
  logic [N_TOT_OF_VC-1:0]            req_i;
  logic [N_TOT_OF_VC*FLIT_WIDTH-1:0] flit_i;
  logic [N_TOT_OF_VC-1:0]            pop_o;
  logic [FLIT_WIDTH-1:0]             out_link_o;
  logic                              is_valid_o;

  modport master (
    output req_i,
    output flit_i,
    input  pop_o,
    input  out_link_o,
    input  is_valid_o
  );

  modport slave (
    input  req_i,
    input  flit_i,
    output pop_o,
    output out_link_o,
    output is_valid_o
  );
endinterface

// File: rtl/nic_vc_scheduler.sv
// rtl/nic_vc_scheduler.sv - injection-side VC scheduler; NIC_VN_PRIORITY_EN gives VN0 strict priority
module nic_vc_scheduler #(
  parameter int N_OF_VC      = 2,
  parameter int N_OF_VN      = 2,
  parameter int FLIT_WIDTH   = 16,
  parameter int BUFFER_DEPTH = 4,
  parameter int CREDIT_WIDTH = 3,
  localparam int N_TOT_OF_VC = N_OF_VC * N_OF_VN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_TOT_OF_VC-1:0] credit_signal_i,
  input  logic [N_TOT_OF_VC-1:0] free_signal_i,
  output logic                   credit_err_o,
  nic_vc_scheduler_if.slave      link
);

  localparam int PTR_W = (N_TOT_OF_VC > 1) ? $clog2(N_TOT_OF_VC) : 1;

  typedef enum logic {VC_IDLE, VC_ACTIVE} vc_state_t;

  vc_state_t               state_q  [N_TOT_OF_VC];
  vc_state_t               state_d  [N_TOT_OF_VC];
  logic [CREDIT_WIDTH-1:0] credit_q [N_TOT_OF_VC];
  logic [1:0]              ftype    [N_TOT_OF_VC];
  logic [N_TOT_OF_VC-1:0]  vc_free_q;
  logic [N_TOT_OF_VC-1:0]  locked;
  logic [N_TOT_OF_VC-1:0]  eligible;
  logic [N_TOT_OF_VC-1:0]  grant;
  logic                    grant_vld;
  logic [PTR_W-1:0]        grant_idx;
  logic [FLIT_WIDTH-1:0]   grant_flit;

`ifdef NIC_VN_PRIORITY_EN
  localparam int N_LO = N_TOT_OF_VC - N_OF_VC;
  logic [PTR_W-1:0] rr_hi_q;
  logic [PTR_W-1:0] rr_lo_q;
`else
  logic [PTR_W-1:0] rr_q;
`endif

  // Per-VC eligibility: a VC may send only if it has credit and the flit type fits its lock state
  always_comb begin
    for (int i = 0; i < N_TOT_OF_VC; i++) begin
      ftype[i]    = link.flit_i[i*FLIT_WIDTH +: 2];
      locked[i]   = (state_q[i] == VC_ACTIVE);
      eligible[i] = link.req_i[i] && (credit_q[i] != '0) &&
                    ((!locked[i] && (ftype[i] == 2'b00 || ftype[i] == 2'b11) && vc_free_q[i]) ||
                     ( locked[i] && (ftype[i] == 2'b01 || ftype[i] == 2'b10)));
    end
  end

  // Round-robin pick of one eligible VC starting at the pointer of the active class
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
`ifdef NIC_VN_PRIORITY_EN
    if (|eligible[N_OF_VC-1:0]) begin
      for (int k = 0; k < N_OF_VC; k++) begin
        if (!grant_vld && eligible[(int'(rr_hi_q) + k) % N_OF_VC]) begin
          grant_vld = 1'b1;
          grant_idx = PTR_W'((int'(rr_hi_q) + k) % N_OF_VC);
        end
      end
    end else begin
      for (int k = 0; k < N_LO; k++) begin
        if (!grant_vld && eligible[N_OF_VC + (int'(rr_lo_q) + k) % N_LO]) begin
          grant_vld = 1'b1;
          grant_idx = PTR_W'(N_OF_VC + (int'(rr_lo_q) + k) % N_LO);
        end
      end
    end
`else
    for (int k = 0; k < N_TOT_OF_VC; k++) begin
      if (!grant_vld && eligible[(int'(rr_q) + k) % N_TOT_OF_VC]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'((int'(rr_q) + k) % N_TOT_OF_VC);
      end
    end
`endif
  end

  // One-hot grant drives the buffer dequeue; suppressed while reset is held
  always_comb begin
    grant = '0;
    if (grant_vld && !rst) grant[grant_idx] = 1'b1;
    grant_flit  = link.flit_i[grant_idx*FLIT_WIDTH +: FLIT_WIDTH];
    link.pop_o  = grant;
  end

  // Wormhole lock next state: head opens the packet, tail closes it, head-tail leaves it idle
  always_comb begin
    for (int i = 0; i < N_TOT_OF_VC; i++) begin
      state_d[i] = state_q[i];
      if (grant[i]) begin
        case (ftype[i])
          2'b00:   state_d[i] = VC_ACTIVE;
          2'b10:   state_d[i] = VC_IDLE;
          default: state_d[i] = state_q[i];
        endcase
      end
    end
  end

  // Lock state and downstream free flags; a head grant beats a same-cycle free pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_TOT_OF_VC; i++) state_q[i] <= VC_IDLE;
      vc_free_q <= '1;
    end else begin
      for (int i = 0; i < N_TOT_OF_VC; i++) begin
        state_q[i] <= state_d[i];
        if (grant[i] && (ftype[i] == 2'b00 || ftype[i] == 2'b11)) vc_free_q[i] <= 1'b0;
        else if (free_signal_i[i])                                vc_free_q[i] <= 1'b1;
      end
    end
  end

  // Credit counters: grant consumes, pulse returns, both cancel; overflow saturates and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_TOT_OF_VC; i++) credit_q[i] <= CREDIT_WIDTH'(BUFFER_DEPTH);
      credit_err_o <= 1'b0;
    end else begin
      for (int i = 0; i < N_TOT_OF_VC; i++) begin
        if (credit_signal_i[i] && !grant[i]) begin
          if (credit_q[i] == CREDIT_WIDTH'(BUFFER_DEPTH)) credit_err_o <= 1'b1;
          else                                            credit_q[i] <= credit_q[i] + 1'b1;
        end else if (grant[i] && !credit_signal_i[i]) begin
          credit_q[i] <= credit_q[i] - 1'b1;
        end
      end
    end
  end

  // Round-robin pointer moves past the granted VC and holds when nothing is granted
  always_ff @(posedge clk) begin
`ifdef NIC_VN_PRIORITY_EN
    if (rst) begin
      rr_hi_q <= '0;
      rr_lo_q <= '0;
    end else if (grant_vld) begin
      if (int'(grant_idx) < N_OF_VC) rr_hi_q <= PTR_W'((int'(grant_idx) + 1) % N_OF_VC);
      else                           rr_lo_q <= PTR_W'((int'(grant_idx) - N_OF_VC + 1) % N_LO);
    end
`else
    if (rst)            rr_q <= '0;
    else if (grant_vld) rr_q <= PTR_W'((int'(grant_idx) + 1) % N_TOT_OF_VC);
`endif
  end

  // Registered link output; the data holds when no flit is sent
  always_ff @(posedge clk) begin
    if (rst) begin
      link.out_link_o <= '0;
      link.is_valid_o <= 1'b0;
    end else if (grant_vld) begin
      link.out_link_o <= grant_flit;
      link.is_valid_o <= 1'b1;
    end else begin
      link.is_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nic_vc_scheduler.sv
// tb/tb_nic_vc_scheduler.sv - directed self-checking bench for nic_vc_scheduler
module tb_nic_vc_scheduler;
  localparam int NV = 4;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NV-1:0] credit_signal;
  logic [NV-1:0] free_signal;
  logic          credit_err;
  int            checks   = 0;
  int            failures = 0;

  nic_vc_scheduler_if #(.N_TOT_OF_VC(NV), .FLIT_WIDTH(FW)) link ();

  nic_vc_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .credit_signal_i (credit_signal),
    .free_signal_i   (free_signal),
    .credit_err_o    (credit_err),
    .link            (link)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flit(input int vc, input logic [FW-1:0] f);
    link.flit_i[vc*FW +: FW] = f;
  endtask

  task automatic clear_inputs();
    link.req_i    = '0;
    link.flit_i   = '0;
    credit_signal = '0;
    free_signal   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [FW-1:0] s0 [3];
    logic [FW-1:0] s1 [3];
    logic [FW-1:0] ilv [6];
    logic [FW-1:0] pk [6];
    logic [NV-1:0] pexp [6];
    logic [NV-1:0] pop_s;
    int            p0, p1, p, sent;
    logic          st0, st3;

    // reset behaviour, pop suppressed while rst is high
    clear_inputs();
    rst         = 1'b1;
    link.req_i  = 4'b0001;
    set_flit(0, 16'h6F03);
    #1 check("pop_in_reset", link.pop_o, 4'b0000);
    tick();
    tick();
    check("reset_outputs", {credit_err, link.is_valid_o, link.out_link_o}, 18'h0);

    // single head-tail flit, then stall until free pulse
    rst = 1'b0;
    #1 check("ht_pop", link.pop_o, 4'b0001);
    tick();
    check("ht_link", {link.is_valid_o, link.out_link_o}, {1'b1, 16'h6F03});
    #1 check("ht_stall", link.pop_o, 4'b0000);
    tick();
    check("link_hold", {link.is_valid_o, link.out_link_o}, {1'b0, 16'h6F03});
    free_signal = 4'b0001;
    #1 check("free_same_cycle", link.pop_o, 4'b0000);
    tick();
    free_signal = 4'b0000;
    #1 check("ht_after_free", link.pop_o, 4'b0001);
    tick();
    check("ht2_link", {link.is_valid_o, link.out_link_o}, {1'b1, 16'h6F03});

    // interleave two 3-flit packets on VC0 and VC1
    do_reset();
    s0  = '{16'hA000, 16'hA101, 16'hA202};
    s1  = '{16'hB000, 16'hB101, 16'hB202};
    ilv = '{16'hA000, 16'hB000, 16'hA101, 16'hB101, 16'hA202, 16'hB202};
    p0 = 0;
    p1 = 0;
    for (int c = 0; c < 6; c++) begin
      link.req_i = {2'b00, (p1 < 3), (p0 < 3)};
      set_flit(0, (p0 < 3) ? s0[p0] : 16'h0);
      set_flit(1, (p1 < 3) ? s1[p1] : 16'h0);
      #1 pop_s = link.pop_o;
      tick();
      if (pop_s[0]) p0++;
      if (pop_s[1]) p1++;
      check($sformatf("interleave%0d", c), {link.is_valid_o, link.out_link_o}, {1'b1, ilv[c]});
    end
    link.req_i = '0;
    tick();
    check("interleave_idle", link.is_valid_o, 1'b0);

    // credit exhaustion on VC2 with a 6-flit packet
    do_reset();
    pk   = '{16'h2400, 16'h2411, 16'h2421, 16'h2431, 16'h2441, 16'h2452};
    p    = 0;
    sent = 0;
    for (int c = 0; c < 8; c++) begin
      link.req_i = (p < 6) ? 4'b0100 : 4'b0000;
      set_flit(2, pk[(p < 6) ? p : 0]);
      #1 pop_s = link.pop_o;
      tick();
      if (pop_s[2]) p++;
      if (link.is_valid_o) sent++;
    end
    check("exhaust_sent", sent, 4);
    check("exhaust_idle", link.is_valid_o, 1'b0);
    credit_signal = 4'b0100;
    #1 check("credit_same_cycle", link.pop_o, 4'b0000);
    tick();
    credit_signal = 4'b0000;
    #1 check("credit_release", link.pop_o, 4'b0100);
    tick();
    check("credit_release_link", {link.is_valid_o, link.out_link_o}, {1'b1, 16'h2441});
    set_flit(2, pk[5]);
    #1 check("credit_one_only", link.pop_o, 4'b0000);
    tick();
    check("credit_one_only_link", link.is_valid_o, 1'b0);

    // grant and credit pulse together, then overflow
    do_reset();
    link.req_i    = 4'b0001;
    set_flit(0, 16'h1233);
    credit_signal = 4'b0001;
    #1 check("grant_and_credit", link.pop_o, 4'b0001);
    tick();
    link.req_i = '0;
    check("no_err_yet", credit_err, 1'b0);
    tick();
    credit_signal = 4'b0000;
    check("overflow_err", credit_err, 1'b1);
    tick();
    tick();
    check("err_sticky", credit_err, 1'b1);

    // reset in the middle of a VC1 packet
    do_reset();
    link.req_i = 4'b0010;
    set_flit(1, 16'hC100);
    #1 check("mid_head", link.pop_o, 4'b0010);
    tick();
    set_flit(1, 16'hC111);
    #1 check("mid_body", link.pop_o, 4'b0010);
    tick();
    rst = 1'b1;
    #1 check("pop_held_in_reset", link.pop_o, 4'b0000);
    tick();
    check("mid_reset_outputs", {credit_err, link.is_valid_o, link.out_link_o}, 18'h0);
    rst           = 1'b0;
    credit_signal = 4'b0010;
    #1 check("stale_body_blocked", link.pop_o, 4'b0000);
    tick();
    credit_signal = 4'b0000;
    check("credit_full_after_reset", credit_err, 1'b1);
    set_flit(1, 16'hC200);
    #1 check("fresh_head", link.pop_o, 4'b0010);
    tick();
    check("fresh_head_link", {link.is_valid_o, link.out_link_o}, {1'b1, 16'hC200});

    // VC0 against VC3
    do_reset();
`ifdef NIC_VN_PRIORITY_EN
    pexp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b1000};
`else
    pexp = '{4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b1000};
`endif
    st0 = 1'b0;
    st3 = 1'b0;
    link.req_i = 4'b1001;
    for (int c = 0; c < 6; c++) begin
      set_flit(0, st0 ? 16'h0A01 : 16'h0A00);
      set_flit(3, st3 ? 16'h3D01 : 16'h3D00);
      #1 pop_s = link.pop_o;
      check($sformatf("arb%0d", c), pop_s, pexp[c]);
      tick();
      if (pop_s[0]) st0 = 1'b1;
      if (pop_s[3]) st3 = 1'b1;
    end
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
